// File: rtl/clk_div_n_if.sv
// clk_div_n_if: control, status and divided-clock signals of the clock divider.
interface clk_div_n_if #(parameter int WIDTH = 8);
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             dout;
  logic             tick;
  logic             err;
  logic [WIDTH-1:0] active_div;
  modport master (output en, div_val, div_load, input dout, tick, err, active_div);
  modport slave  (input en, div_val, div_load, output dout, tick, err, active_div);
endinterface

// File: rtl/clk_div_n.sv
// clk_div_n: divide-by-N clock with 50% duty for odd and even N, glitch-free divisor updates.
module clk_div_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input logic         clk,
  input logic         rst,
  clk_div_n_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d;
  logic             p_q, p_d, tick_q, tick_d, err_q, err_d, n_q;
  logic             wrap, legal;
  assign wrap  = cnt_q == act_q - WIDTH'(1);
  assign legal = bus.div_val > WIDTH'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= WIDTH'(DEFAULT_DIV);
      act_q   <= WIDTH'(DEFAULT_DIV);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
    end
  end
  // Half-cycle stretch of the high phase; only odd divisors need it.
  always_ff @(negedge clk)
    n_q <= rst ? 1'b0 : (act_q[0] & p_q);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pend_d  = pend_q;
    err_d   = err_q;
    if (bus.div_load) begin
      pend_d = legal ? bus.div_val : pend_q;
      err_d  = !legal;
    end
    if (state_q == IDLE) begin
      state_d = bus.en ? RUN : IDLE;
      cnt_d   = '0;
      act_d   = bus.en ? pend_q : act_q;
    end else if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
      act_d = wrap ? pend_q : act_q;
    end
    p_d    = (state_d == RUN) && (cnt_d < (act_d >> 1));
    tick_d = (state_d == RUN) && (cnt_d == '0);
  end
  assign bus.dout       = p_q | n_q;
  assign bus.tick       = tick_q;
  assign bus.err        = err_q;
  assign bus.active_div = act_q;
endmodule
